// File: rtl/gb_cart_pkg.sv
// Shared constants and types for the GameBoy MBC1 cartridge controller.
// Address windows are decoded from the top address bits in 8 KB or 16 KB granules.
package gb_cart_pkg;

  // CART_ADDR[15:14] windows (16 KB)
  localparam logic [1:0] WinRom0 = 2'b00;
  localparam logic [1:0] WinRomx = 2'b01;

  // CART_ADDR[15:13] windows (8 KB)
  localparam logic [2:0] WinRamEn = 3'b000;
  localparam logic [2:0] WinBank1 = 3'b001;
  localparam logic [2:0] WinBank2 = 3'b010;
  localparam logic [2:0] WinMode  = 3'b011;
  localparam logic [2:0] WinEram  = 3'b101;

  localparam logic [3:0] RamEnKey = 4'hA;
  localparam logic [7:0] OpenBus  = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StRomWait,
    StRamWait
  } rd_state_e;

  // Full 7-bit ROM bank before masking to the populated bank count.
  function automatic logic [6:0] rom_bank(input logic       in_rom0,
                                          input logic       mode,
                                          input logic [1:0] bank2,
                                          input logic [4:0] bank1);
    if (in_rom0) begin
      return mode ? {bank2, 5'b00000} : 7'd0;
    end
    return {bank2, bank1};
  endfunction

endpackage

// File: rtl/mbc1_regs.sv
// MBC1 control registers (ram_en, bank1, bank2, mode) and the ROM/RAM address
// mapping derived from them and the current cartridge address.
module mbc1_regs
  import gb_cart_pkg::*;
#(
  parameter int unsigned ROM_BANKS_LOG2 = 7,
  parameter int unsigned RAM_BANKS_LOG2 = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_wr_stb,
  input  logic [15:0]                     i_addr,
  input  logic [4:0]                      i_data,
  output logic                            o_ram_en,
  output logic [14+ROM_BANKS_LOG2-1:0]    o_rom_addr,
  output logic [13+RAM_BANKS_LOG2-1:0]    o_ram_addr
);

  logic [4:0]  r_bank1;
  logic [1:0]  r_bank2;
  logic        r_mode;
  logic        r_ram_en;

  logic [20:0] w_rom_full;
  logic [14:0] w_ram_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bank1  <= 5'd1;
      r_bank2  <= 2'd0;
      r_mode   <= 1'b0;
      r_ram_en <= 1'b0;
    end else if (i_wr_stb) begin
      case (i_addr[15:13])
        WinRamEn: r_ram_en <= (i_data[3:0] == RamEnKey);
        // Bank 0 is unreachable through the switchable window
        WinBank1: r_bank1  <= (i_data == 5'd0) ? 5'd1 : i_data;
        WinBank2: r_bank2  <= i_data[1:0];
        WinMode:  r_mode   <= i_data[0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    w_rom_full = {rom_bank(i_addr[15:14] == WinRom0, r_mode, r_bank2, r_bank1), i_addr[13:0]};
    w_ram_full = {(r_mode ? r_bank2 : 2'b00), i_addr[12:0]};
  end

  assign o_ram_en   = r_ram_en;
  assign o_rom_addr = w_rom_full[14+ROM_BANKS_LOG2-1:0];
  assign o_ram_addr = w_ram_full[13+RAM_BANKS_LOG2-1:0];

endmodule

// File: rtl/cart_mbc1.sv
// MBC1 cartridge front end: write decode, read-fetch FSM towards the ROM store
// and cartridge SRAM, and the registered data return path to the GameBoy.
module cart_mbc1
  import gb_cart_pkg::*;
#(
  parameter int unsigned ROM_BANKS_LOG2 = 7,
  parameter int unsigned RAM_BANKS_LOG2 = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [15:0]                     CART_ADDR,
  input  logic [7:0]                      CART_DATA_from_gb,
  output logic [7:0]                      CART_DATA_to_gb,
  input  logic                            CART_RD,
  input  logic                            CART_WR,
  output logic                            CART_BUSY,
  output logic [14+ROM_BANKS_LOG2-1:0]    ROM_ADDR,
  output logic                            ROM_RD,
  input  logic [7:0]                      ROM_RDATA,
  input  logic                            ROM_VALID,
  output logic [13+RAM_BANKS_LOG2-1:0]    RAM_ADDR,
  output logic                            RAM_WR,
  output logic [7:0]                      RAM_WDATA,
  input  logic [7:0]                      RAM_RDATA
);

  rd_state_e r_state;
  rd_state_e w_state_next;

  logic        r_rd_q;
  logic        r_wr_q;
  logic [15:0] r_addr_q;
  logic        r_pending;
  logic [7:0]  r_data;
  logic        r_ram_wr;
  logic [7:0]  r_ram_wdata;
  logic [14+ROM_BANKS_LOG2-1:0] r_rom_addr;

  logic        w_wr_stb;
  logic        w_rd_start;
  logic        w_issue;
  logic        w_is_rom;
  logic        w_is_eram;
  logic        w_ram_en;
  logic        w_go_rom;
  logic        w_go_ram;
  logic        w_go_open;
  logic [14+ROM_BANKS_LOG2-1:0] w_rom_addr;

  assign w_wr_stb   = CART_WR & ~r_wr_q;
  // A simultaneous write owns the bus; the read start is dropped, not deferred
  assign w_rd_start = CART_RD & ~CART_WR & (~r_rd_q | (CART_ADDR != r_addr_q));
  assign w_issue    = (r_state == StIdle) & (w_rd_start | r_pending);

  assign w_is_rom   = (CART_ADDR[15:14] == WinRom0) | (CART_ADDR[15:14] == WinRomx);
  assign w_is_eram  = (CART_ADDR[15:13] == WinEram);
  assign w_go_rom   = w_issue & w_is_rom;
  assign w_go_ram   = w_issue & w_is_eram & w_ram_en;
  assign w_go_open  = w_issue & ~w_is_rom & ~(w_is_eram & w_ram_en);

  mbc1_regs #(
    .ROM_BANKS_LOG2 (ROM_BANKS_LOG2),
    .RAM_BANKS_LOG2 (RAM_BANKS_LOG2)
  ) u_regs (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr_stb   (w_wr_stb),
    .i_addr     (CART_ADDR),
    .i_data     (CART_DATA_from_gb[4:0]),
    .o_ram_en   (w_ram_en),
    .o_rom_addr (w_rom_addr),
    .o_ram_addr (RAM_ADDR)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_q   <= 1'b0;
      r_wr_q   <= 1'b0;
      r_addr_q <= '0;
    end else begin
      r_rd_q   <= CART_RD;
      r_wr_q   <= CART_WR;
      r_addr_q <= CART_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_go_rom) begin
          w_state_next = StRomWait;
        end else if (w_go_ram) begin
          w_state_next = StRamWait;
        end
      end
      StRomWait: if (ROM_VALID) w_state_next = StIdle;
      StRamWait: w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    ROM_RD    = 1'b0;
    CART_BUSY = 1'b0;
    unique case (r_state)
      StRomWait: begin
        ROM_RD    = 1'b1;
        CART_BUSY = 1'b1;
      end
      StRamWait: CART_BUSY = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= 1'b0;
      r_data      <= OpenBus;
      r_rom_addr  <= '0;
      r_ram_wr    <= 1'b0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_wr <= w_wr_stb & w_is_eram & w_ram_en;
      if (w_wr_stb) r_ram_wdata <= CART_DATA_from_gb;

      // One deferred start is remembered; it re-samples CART_ADDR when issued
      if (r_state != StIdle) begin
        if (w_rd_start) r_pending <= 1'b1;
      end else begin
        r_pending <= 1'b0;
      end

      // Latched so bank writes during the fetch cannot move it
      if (w_go_rom) r_rom_addr <= w_rom_addr;

      if (w_go_open) begin
        r_data <= OpenBus;
      end else if ((r_state == StRomWait) && ROM_VALID) begin
        r_data <= ROM_RDATA;
      end else if (r_state == StRamWait) begin
        r_data <= RAM_RDATA;
      end
    end
  end

  assign ROM_ADDR        = r_rom_addr;
  assign RAM_WR          = r_ram_wr;
  assign RAM_WDATA       = r_ram_wdata;
  assign CART_DATA_to_gb = r_data;

endmodule

// File: tb/tb_cart_mbc1.sv
// Bench for cart_mbc1: directed scenarios plus random cartridge traffic, all
// checked each cycle against a bank/mode model and an SRAM image held here.
module tb_cart_mbc1;

  localparam int unsigned RomLog2 = 7;
  localparam int unsigned RamLog2 = 2;
  localparam int RomSpan = 1 << (14 + RomLog2);
  localparam int RamSpan = 1 << (13 + RamLog2);

  logic                   clk = 1'b0;
  logic                   rst;
  logic [15:0]            cart_addr;
  logic [7:0]             cart_wdata;
  logic [7:0]             cart_rdata;
  logic                   cart_rd;
  logic                   cart_wr;
  logic                   cart_busy;
  logic [14+RomLog2-1:0]  rom_addr;
  logic                   rom_rd;
  logic [7:0]             rom_rdata;
  logic                   rom_valid;
  logic [13+RamLog2-1:0]  ram_addr;
  logic                   ram_wr;
  logic [7:0]             ram_wdata;
  logic [7:0]             ram_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cart_mbc1 #(
    .ROM_BANKS_LOG2 (RomLog2),
    .RAM_BANKS_LOG2 (RamLog2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .CART_ADDR         (cart_addr),
    .CART_DATA_from_gb (cart_wdata),
    .CART_DATA_to_gb   (cart_rdata),
    .CART_RD           (cart_rd),
    .CART_WR           (cart_wr),
    .CART_BUSY         (cart_busy),
    .ROM_ADDR          (rom_addr),
    .ROM_RD            (rom_rd),
    .ROM_RDATA         (rom_rdata),
    .ROM_VALID         (rom_valid),
    .RAM_ADDR          (ram_addr),
    .RAM_WR            (ram_wr),
    .RAM_WDATA         (ram_wdata),
    .RAM_RDATA         (ram_rdata)
  );

  function automatic logic [7:0] fill(input int a);
    return 8'((a & 'hFF) ^ ((a >> 8) & 'hFF));
  endfunction

  // Cartridge SRAM: read data valid one clock after the address.
  bit [7:0] sram     [RamSpan];
  bit       sram_vld [RamSpan];
  always @(posedge clk) begin
    if (ram_wr) begin
      sram[ram_addr]     <= ram_wdata;
      sram_vld[ram_addr] <= 1'b1;
    end
    ram_rdata <= sram_vld[ram_addr] ? sram[ram_addr] : fill(int'(ram_addr));
  end

  // Reference model of the mapper state.
  int       m_bank1, m_bank2, m_mode, m_ram_en;
  bit [7:0] m_mem [RamSpan];
  bit       m_vld [RamSpan];

  function automatic void model_reset();
    m_bank1  = 1;
    m_bank2  = 0;
    m_mode   = 0;
    m_ram_en = 0;
  endfunction

  function automatic bit is_eram(input int a);
    return (a >= 'hA000) && (a < 'hC000);
  endfunction

  function automatic int model_rom_addr(input int a);
    int bank;
    if (a < 'h4000) bank = (m_mode != 0) ? m_bank2 * 32 : 0;
    else            bank = m_bank2 * 32 + m_bank1;
    return (bank * 'h4000 + a % 'h4000) % RomSpan;
  endfunction

  function automatic int model_ram_addr(input int a);
    return (((m_mode != 0) ? m_bank2 : 0) * 'h2000 + a % 'h2000) % RamSpan;
  endfunction

  function automatic logic [7:0] model_ram_read(input int ra);
    return m_vld[ra] ? m_mem[ra] : fill(ra);
  endfunction

  function automatic void model_write(input int a, input int d);
    int ra;
    if (a < 'h2000)      m_ram_en = (d % 16 == 10) ? 1 : 0;
    else if (a < 'h4000) m_bank1  = (d % 32 == 0) ? 1 : d % 32;
    else if (a < 'h6000) m_bank2  = d % 4;
    else if (a < 'h8000) m_mode   = d % 2;
    else if (is_eram(a) && (m_ram_en != 0)) begin
      ra        = model_ram_addr(a);
      m_mem[ra] = 8'(d);
      m_vld[ra] = 1'b1;
    end
  endfunction

  // Expected outputs for the current cycle, compared on the falling edge.
  bit       chk_en = 1'b0;
  logic     exp_busy, exp_rom_rd, exp_ram_wr;
  logic [7:0] exp_data, exp_ram_wdata;
  int       exp_rom_addr, exp_ram_addr;

  int          obs_busy, obs_pulses;
  logic [31:0] obs_rom_addr, obs_ram_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(cart_busy), 32'(exp_busy));
      check("rom_rd", 32'(rom_rd), 32'(exp_rom_rd));
      check("data", 32'(cart_rdata), 32'(exp_data));
      check("ram_wr", 32'(ram_wr), 32'(exp_ram_wr));
      if (exp_rom_rd) check("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
      if (exp_ram_wr) begin
        check("ram_addr", 32'(ram_addr), 32'(exp_ram_addr));
        check("ram_wdata", 32'(ram_wdata), 32'(exp_ram_wdata));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    exp_ram_wr = 1'b0;
    rom_valid  = 1'b0;
  endtask

  task automatic set_idle_exp();
    exp_busy   = 1'b0;
    exp_rom_rd = 1'b0;
  endtask

  // Idle cycles with stray ROM_VALID pulses that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      rom_valid = ($urandom_range(0, 3) == 0);
      rom_rdata = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic cart_write(input int a, input int d, input int hold);
    step();
    cart_addr  = 16'(a);
    cart_wdata = 8'(d);
    cart_wr    = 1'b1;
    obs_pulses = 0;
    step();
    exp_ram_wr = is_eram(a) && (m_ram_en != 0);
    if (exp_ram_wr) begin
      exp_ram_addr  = model_ram_addr(a);
      exp_ram_wdata = 8'(d);
    end
    model_write(a, d);
    if (ram_wr) obs_pulses++;
    for (int i = 2; i < hold; i++) begin
      step();
      if (ram_wr) obs_pulses++;
    end
    step();
    cart_wr = 1'b0;
    if (ram_wr) obs_pulses++;
  endtask

  task automatic cart_read(input int a, input int lat, input logic [7:0] rd);
    step();
    cart_addr    = 16'(a);
    cart_rd      = 1'b1;
    obs_busy     = 0;
    obs_rom_addr = '0;
    obs_ram_addr = '0;
    if (a < 'h8000) begin
      exp_rom_addr = model_rom_addr(a);
      for (int i = 1; i <= lat; i++) begin
        step();
        exp_busy   = 1'b1;
        exp_rom_rd = 1'b1;
        if (cart_busy) obs_busy++;
        if (i == 1) obs_rom_addr = 32'(rom_addr);
        rom_rdata = (i == lat) ? rd : 8'($urandom_range(0, 255));
        rom_valid = (i == lat);
      end
      step();
      set_idle_exp();
      exp_data = rd;
      if (cart_busy) obs_busy++;
    end else if (is_eram(a) && (m_ram_en != 0)) begin
      step();
      exp_busy     = 1'b1;
      obs_ram_addr = 32'(ram_addr);
      if (cart_busy) obs_busy++;
      step();
      set_idle_exp();
      exp_data = model_ram_read(model_ram_addr(a));
    end else begin
      step();
      exp_data = 8'hFF;
    end
    step();
    cart_rd = 1'b0;
  endtask

  int a, d;

  initial begin
    rst        = 1'b1;
    cart_addr  = '0;
    cart_wdata = '0;
    cart_rd    = 1'b0;
    cart_wr    = 1'b0;
    rom_rdata  = '0;
    rom_valid  = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_reset();
    set_idle_exp();
    exp_data = 8'hFF;
    chk_en   = 1'b1;

    check("rst_data", 32'(cart_rdata), 32'h0000_00FF);
    check("rst_busy", 32'(cart_busy), 32'h0);
    check("rst_rom_rd", 32'(rom_rd), 32'h0);
    idle(2);

    // First fetch after reset: bank 1, three wait cycles
    cart_read('h4000, 3, 8'h3C);
    check("r035_addr", obs_rom_addr, 32'h0000_4000);
    check("r035_busy", 32'(obs_busy), 32'd3);
    check("r035_data", 32'(cart_rdata), 32'h3C);

    cart_write('h2000, 'h00, 3);
    cart_read('h4000, 2, 8'h11);
    check("r036_bank0", obs_rom_addr, 32'h0000_4000);
    cart_write('h2000, 'h1F, 2);
    cart_write('h4000, 'h03, 2);
    cart_read('h7FFF, 1, 8'h22);
    check("r036_top", obs_rom_addr, 32'h001F_FFFF);

    cart_write('h6000, 'h01, 2);
    cart_write('h4000, 'h02, 2);
    cart_read('h0000, 2, 8'h33);
    check("r037_rom0", obs_rom_addr, 32'h0010_0000);
    cart_write('h0000, 'h0A, 2);
    cart_read('hA123, 1, 8'h00);
    check("r037_ram", obs_ram_addr, 32'h0000_4123);

    cart_write('h0000, 'h0B, 2);
    cart_write('hA000, 'h55, 4);
    check("r038_off_pulses", 32'(obs_pulses), 32'd0);
    cart_read('hA000, 1, 8'h00);
    check("r038_off_data", 32'(cart_rdata), 32'hFF);
    cart_write('h0000, 'h0A, 2);
    cart_write('hA000, 'h55, 4);
    check("r038_on_pulses", 32'(obs_pulses), 32'd1);
    cart_read('hA000, 1, 8'h00);
    check("r038_readback", 32'(cart_rdata), 32'h55);

    // Write and read strobes together: the bank write lands, no fetch starts
    step();
    cart_addr  = 16'h2000;
    cart_wdata = 8'h07;
    cart_wr    = 1'b1;
    cart_rd    = 1'b1;
    step();
    model_write('h2000, 'h07);
    step();
    cart_wr = 1'b0;
    step();
    check("r028_nobusy", 32'(cart_busy), 32'h0);
    step();
    cart_rd = 1'b0;
    cart_read('h4000, 1, 8'h44);
    check("r028_bank", obs_rom_addr, 32'h0011_C000);

    // Bank write while a fetch is outstanding
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    set_idle_exp();
    exp_data = 8'hFF;
    step();
    cart_addr = 16'h4000;
    cart_rd   = 1'b1;
    exp_rom_addr = model_rom_addr('h4000);
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_busy   = 1'b1;
      exp_rom_rd = 1'b1;
      case (i)
        1: cart_rd = 1'b0;
        2: begin
          cart_addr  = 16'h2000;
          cart_wdata = 8'h05;
          cart_wr    = 1'b1;
        end
        3: model_write('h2000, 'h05);
        5: cart_wr = 1'b0;
        7: check("r039_inflight", 32'(rom_addr), 32'h0000_4000);
        default: ;
      endcase
      rom_rdata = 8'h77;
      rom_valid = (i == 8);
    end
    step();
    set_idle_exp();
    exp_data = 8'h77;
    cart_read('h4000, 2, 8'h66);
    check("r039_next", obs_rom_addr, 32'h0001_4000);

    // Address change during a fetch is deferred and issued afterwards
    step();
    cart_addr    = 16'h4000;
    cart_rd      = 1'b1;
    exp_rom_addr = model_rom_addr('h4000);
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_busy   = 1'b1;
      exp_rom_rd = 1'b1;
      if (i == 2) cart_addr = 16'h0123;
      rom_rdata = 8'h5A;
      rom_valid = (i == 4);
    end
    step();
    set_idle_exp();
    exp_data     = 8'h5A;
    exp_rom_addr = model_rom_addr('h0123);
    for (int i = 1; i <= 2; i++) begin
      step();
      exp_busy   = 1'b1;
      exp_rom_rd = 1'b1;
      if (i == 1) check("r027_deferred", 32'(rom_addr), 32'h0000_0123);
      rom_rdata = 8'hA5;
      rom_valid = (i == 2);
    end
    step();
    set_idle_exp();
    exp_data = 8'hA5;
    step();
    cart_rd = 1'b0;

    // Reset during a fetch; the late ROM_VALID must be ignored
    cart_write('h4000, 'h01, 2);
    cart_write('h6000, 'h01, 2);
    cart_write('h0000, 'h0A, 2);
    step();
    cart_addr    = 16'h4000;
    cart_rd      = 1'b1;
    exp_rom_addr = model_rom_addr('h4000);
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_busy   = 1'b1;
      exp_rom_rd = 1'b1;
    end
    rst     = 1'b1;
    cart_rd = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
    set_idle_exp();
    exp_data = 8'hFF;
    step();
    step();
    rom_rdata = 8'h99;
    rom_valid = 1'b1;
    step();
    check("r040_data", 32'(cart_rdata), 32'hFF);
    check("r040_rom_rd", 32'(rom_rd), 32'h0);
    cart_read('h0000, 1, 8'h12);
    check("r040_mode", obs_rom_addr, 32'h0000_0000);
    cart_read('h4000, 1, 8'h13);
    check("r040_bank", obs_rom_addr, 32'h0000_4000);
    cart_write('hA000, 'h21, 3);
    check("r040_ram_en", 32'(obs_pulses), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) < 4) begin
        case ($urandom_range(0, 5))
          0: begin
            a = $urandom_range(0, 'h1FFF);
            d = ($urandom_range(0, 3) != 0) ? (($urandom_range(0, 15) << 4) | 'hA)
                                            : $urandom_range(0, 255);
          end
          1: begin a = $urandom_range('h2000, 'h3FFF); d = $urandom_range(0, 255); end
          2: begin a = $urandom_range('h4000, 'h5FFF); d = $urandom_range(0, 255); end
          3: begin a = $urandom_range('h6000, 'h7FFF); d = $urandom_range(0, 255); end
          4: begin a = $urandom_range('hA000, 'hBFFF); d = $urandom_range(0, 255); end
          default: begin
            a = ($urandom_range(0, 1) != 0) ? $urandom_range('h8000, 'h9FFF)
                                            : $urandom_range('hC000, 'hFFFF);
            d = $urandom_range(0, 255);
          end
        endcase
        cart_write(a, d, $urandom_range(2, 5));
      end else begin
        case ($urandom_range(0, 4))
          0:       a = $urandom_range(0, 'h3FFF);
          1:       a = $urandom_range('h4000, 'h7FFF);
          2, 3:    a = $urandom_range('hA000, 'hBFFF);
          default: a = ($urandom_range(0, 1) != 0) ? $urandom_range('h8000, 'h9FFF)
                                                   : $urandom_range('hC000, 'hFFFF);
        endcase
        cart_read(a, $urandom_range(1, 5), 8'($urandom_range(0, 255)));
      end
      idle($urandom_range(0, 2));
    end

    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cart_mbc1.md
CART_MBC1 -- requirements
Module: cart_mbc1

Interface
REQ-001 Parameter ROM_BANKS_LOG2, default 7, log2 of ROM bank count; ROM bank numbers SHALL be masked to this width.
REQ-002 Parameter RAM_BANKS_LOG2, default 2, log2 of 8 KB RAM bank count (0..2); RAM bank bits SHALL be masked to this width.
REQ-003 clk  in  1  single system clock; all state SHALL be updated on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 CART_ADDR  in  16  GameBoy cartridge address.
REQ-006 CART_DATA_from_gb  in  8  write data from GameBoy.
REQ-007 CART_DATA_to_gb  out  8  registered read data to GameBoy.
REQ-008 CART_RD / CART_WR  in  1 each  high-active strobes, level held several clocks per access.
REQ-009 CART_BUSY  out  1  high while a read fetch is outstanding.
REQ-010 ROM_ADDR  out  14+ROM_BANKS_LOG2  byte address to ROM store.
REQ-011 ROM_RD  out  1  fetch request, held until ROM_VALID.
REQ-012 ROM_RDATA / ROM_VALID  in  8 / 1  ROM data, qualified by one-cycle valid pulse, arbitrary latency.
REQ-013 RAM_ADDR  out  13+RAM_BANKS_LOG2  cartridge SRAM address; RAM_WR out 1; RAM_WDATA out 8; RAM_RDATA in 8 (valid one clock after address).

Function
REQ-014 Write decode SHALL act once per CART_WR rising edge (registered edge detect), using address/data sampled that cycle.
REQ-015 0000-1FFF write: ram_en SHALL become 1 iff data[3:0]==4'hA, else 0.
REQ-016 2000-3FFF write: bank1 (5 bits) SHALL take data[4:0]; value 0 SHALL be stored as 1.
REQ-017 4000-5FFF write: bank2 (2 bits) SHALL take data[1:0]; 6000-7FFF write: mode SHALL take data[0].
REQ-018 A000-BFFF write with ram_en=1: RAM_WR SHALL pulse exactly one cycle with RAM_WDATA=data; ram_en=0: no RAM_WR.
REQ-019 Writes to any other address SHALL be ignored.
REQ-020 ROM address: 0000-3FFF -> bank (mode ? {bank2,5'b0} : 0); 4000-7FFF -> bank {bank2,bank1}; offset CART_ADDR[13:0]; bank masked per REQ-001.
REQ-021 RAM address: {mode ? bank2 : 2'b0, CART_ADDR[12:0]}, masked per REQ-002.
REQ-022 Read FSM states IDLE, ROM_WAIT, RAM_WAIT; fetch SHALL start on CART_RD rising edge, or on CART_ADDR change while CART_RD high.
REQ-023 IDLE->ROM_WAIT for ROM-range read: ROM_RD high, ROM_ADDR latched; ROM_WAIT->IDLE on ROM_VALID, CART_DATA_to_gb<=ROM_RDATA same edge.
REQ-024 IDLE->RAM_WAIT for A000-BFFF with ram_en=1; after exactly one cycle CART_DATA_to_gb<=RAM_RDATA, ->IDLE.
REQ-025 A000-BFFF read with ram_en=0, or any non-cartridge address: CART_DATA_to_gb<=8'hFF next cycle, no ROM_RD.
REQ-026 CART_BUSY SHALL equal (state!=IDLE).
REQ-027 Fetch start while not IDLE SHALL be deferred until IDLE, then issued with current address; at most one pending.
REQ-028 CART_RD and CART_WR both high: write SHALL be honoured, read start suppressed.
REQ-029 Bank/mode writes during ROM_WAIT SHALL NOT alter the latched in-flight ROM_ADDR.
REQ-030 ROM_VALID outside ROM_WAIT SHALL be ignored.

Reset
REQ-031 On rst: bank1=1, bank2=0, mode=0, ram_en=0, state=IDLE, CART_DATA_to_gb=8'hFF, ROM_RD=0, RAM_WR=0, CART_BUSY=0, edge detectors cleared.
REQ-032 rst during ROM_WAIT SHALL drop ROM_RD next edge; subsequent stale ROM_VALID SHALL NOT update CART_DATA_to_gb.

Structure
REQ-033 Package gb_cart_pkg SHALL hold address-range constants (ROM0, ROMX, MBC register windows, ERAM) and the read-FSM state enum.
REQ-034 Bank/mode/ram_en registers and address mapping SHALL live in one sub-module, mbc1_regs; fetch FSM in cart_mbc1.

Verification
REQ-035 Post-reset, read 4000 with ROM_VALID after 3 cycles -> ROM_ADDR=0x04000, CART_BUSY high 3 cycles, data=ROM_RDATA.
REQ-036 Write 2000<=0x00 then read 4000 -> bank 1, ROM_ADDR=0x04000; write 2000<=0x1F, 4000<=0x03, read 7FFF -> ROM_ADDR=0x1FFFFF (ROM_BANKS_LOG2=7).
REQ-037 Mode=1, bank2=2: read 0000 -> ROM_ADDR=0x100000; read A123 with ram_en=1 -> RAM_ADDR=0x4123.
REQ-038 RAM disabled (0000<=0x0B): write A000<=0x55 -> no RAM_WR; read A000 -> 0xFF; enable (0x0A), write -> single RAM_WR pulse, WR held 4 cycles.
REQ-039 Write 2000<=0x05 during ROM_WAIT -> in-flight ROM_ADDR unchanged; next read uses bank 5.
REQ-040 Assert rst in ROM_WAIT, ROM_VALID 2 cycles later -> ROM_RD low, data stays 0xFF, registers at reset values.
